mc_control_unit: RTL and testbench

Multi-cycle RV32I control unit with parametrised memory timeout. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It latches the instruction word on the fetch handshake and holds decoded datapath controls stable for the whole instruction. It issues one-cycle write strobes and counts retired instructions, and it sits between the instruction/data memory port and the single-ported datapath (regfile, ALU, PC unit).

---
 rtl/mc_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, holds decoded
// datapath controls per instruction, times out stalled memory and counts retirements.
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ack,
    input  logic             halt,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             branch,
    output logic             load,
    output logic             store,
    output logic             opB,
    output logic [1:0]       opA,
    output logic [2:0]       imm_sel,
    output logic [1:0]       next_sel,
    output logic [1:0]       wb_sel,
    output logic [3:0]       ALU_C,
    output logic             trap,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);

    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t        state;
    logic [6:0]    op_q;
    logic [2:0]    f3_q;
    logic          i30_q;
    logic          fetch_busy;
    logic [TW-1:0] wait_cnt;
    logic          fetch_req;
    logic          timeout_hit;
    logic          unused_instr_bits;

    logic          d_branch, d_load, d_store, d_opb, d_illegal;
    logic [1:0]    d_opa, d_next, d_wb;
    logic [2:0]    d_imm;
    logic [3:0]    d_alu;

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Once a fetch request has gone out it stays up until acked, whatever halt does.
    assign fetch_req   = (state == S_FETCH) && (!halt || fetch_busy);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ack
                         && (wait_cnt == TW'(MEM_TIMEOUT - 1));

    always_comb begin
        d_branch  = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_opb     = 1'b0;
        d_opa     = 2'b00;
        d_imm     = 3'b000;
        d_next    = 2'b00;
        d_wb      = 2'b00;
        d_alu     = 4'b0000;
        d_illegal = 1'b0;
        case (op_q)
            OP_R: begin
                d_alu     = {i30_q, f3_q};
                d_illegal = i30_q && (f3_q != 3'b000) && (f3_q != 3'b101);
            end
            OP_IMM: begin
                d_opb     = 1'b1;
                d_alu     = (f3_q == 3'b101) ? {i30_q, f3_q} : {1'b0, f3_q};
                d_illegal = (f3_q == 3'b001) && i30_q;
            end
            // Immediate-operand ALU uses (LUI/AUIPC/load/store address) feed the immediate on B.
            OP_LUI: begin
                d_opb = 1'b1;
                d_opa = 2'b10;
                d_imm = 3'b011;
                d_alu = 4'b1111;
            end
            OP_AUIPC: begin
                d_opb = 1'b1;
                d_opa = 2'b01;
                d_imm = 3'b011;
            end
            OP_JAL: begin
                d_next = 2'b10;
                d_wb   = 2'b10;
                d_imm  = 3'b100;
            end
            OP_JALR: begin
                d_next = 2'b11;
                d_wb   = 2'b10;
            end
            OP_BRANCH: begin
                d_branch  = 1'b1;
                d_alu     = 4'b1000;
                d_imm     = 3'b010;
                d_next    = 2'b01;
                d_illegal = (f3_q == 3'b010) || (f3_q == 3'b011);
            end
            OP_LOAD: begin
                d_load = 1'b1;
                d_opb  = 1'b1;
                d_wb   = 2'b01;
            end
            OP_STORE: begin
                d_store = 1'b1;
                d_opb   = 1'b1;
                d_imm   = 3'b001;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = fetch_req;
                ir_write = fetch_req && mem_ack;
            end
            S_EXEC: pc_write = branch;
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = store;
                addr_sel = 1'b1;
                pc_write = store && mem_ack;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            f3_q       <= '0;
            i30_q      <= 1'b0;
            fetch_busy <= 1'b0;
            wait_cnt   <= '0;
            branch     <= 1'b0;
            load       <= 1'b0;
            store      <= 1'b0;
            opB        <= 1'b0;
            opA        <= '0;
            imm_sel    <= '0;
            next_sel   <= '0;
            wb_sel     <= '0;
            ALU_C      <= '0;
            trap       <= 1'b0;
            fault      <= '0;
            instret    <= '0;
        end else begin
            if (pc_write)
                instret <= instret + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    state      <= S_FETCH;
                    fetch_busy <= 1'b0;
                    wait_cnt   <= '0;
                end
                S_FETCH: begin
                    if (timeout_hit) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                        fault <= 2'b10;
                    end else if (mem_req && mem_ack) begin
                        op_q       <= instr[6:0];
                        f3_q       <= instr[14:12];
                        i30_q      <= instr[30];
                        fetch_busy <= 1'b0;
                        state      <= S_DECODE;
                    end else if (mem_req) begin
                        fetch_busy <= 1'b1;
                        wait_cnt   <= wait_cnt + TW'(1);
                    end
                end
                S_DECODE: begin
                    if (d_illegal) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                        fault <= 2'b01;
                    end else begin
                        branch   <= d_branch;
                        load     <= d_load;
                        store    <= d_store;
                        opB      <= d_opb;
                        opA      <= d_opa;
                        imm_sel  <= d_imm;
                        next_sel <= d_next;
                        wb_sel   <= d_wb;
                        ALU_C    <= d_alu;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (branch)
                        state <= S_FETCH;
                    else if (load || store)
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (timeout_hit) begin
                        state <= S_TRAP;
                        trap  <= 1'b1;
                        fault <= 2'b10;
                    end else if (mem_ack) begin
                        wait_cnt <= '0;
                        state    <= load ? S_WB : S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                S_TRAP: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: decode table, hand-written multi-cycle
// corner cases and a randomized instruction stream against a per-cycle timeline model.
module tb_mc_control_unit;

    localparam int TMO = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instr;
    logic          mem_ack, halt;
    logic          mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
    logic          branch, load, store, opB, trap;
    logic [1:0]    opA, next_sel, wb_sel, fault;
    logic [2:0]    imm_sel;
    logic [3:0]    ALU_C;
    logic [CW-1:0] instret;

    mc_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack), .halt(halt),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .branch(branch), .load(load),
        .store(store), .opB(opB), .opA(opA), .imm_sel(imm_sel), .next_sel(next_sel),
        .wb_sel(wb_sel), .ALU_C(ALU_C), .trap(trap), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    // One expected clock cycle of the instruction timeline.
    typedef struct packed {
        logic       halt_forced;
        logic       halt_val;
        logic       fetch;
        logic       ack;
        logic       req;
        logic       we;
        logic       asel;
        logic       irw;
        logic       pcw;
        logic       rgw;
        logic       new_ctl;
        logic       trapd;
        logic [1:0] flt;
    } cyc_t;

    typedef struct {
        logic [31:0] word;
        logic [16:0] ctl;
        logic        ill;
    } vec_t;

    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_instret = '0;
    logic [16:0]   prev_ctl = '0;
    wire  [16:0]   dut_ctl = {branch, load, store, opB, opA, imm_sel, next_sel, wb_sel, ALU_C};

    function automatic logic [16:0] mk(input logic b, input logic l, input logic s,
                                       input logic ob, input logic [1:0] oa,
                                       input logic [2:0] im, input logic [1:0] nx,
                                       input logic [1:0] wb, input logic [3:0] alu);
        return {b, l, s, ob, oa, im, nx, wb, alu};
    endfunction

    // Reference decoder: returns {illegal, controls}.
    function automatic logic [17:0] decode_ref(input logic [31:0] w);
        logic [2:0] f3;
        logic       i30;
        f3  = w[14:12];
        i30 = w[30];
        case (w[6:0])
            7'b0110011: return {i30 && (f3 != 3'd0) && (f3 != 3'd5),
                                mk(0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, {i30, f3})};
            7'b0010011: return {(f3 == 3'd1) && i30,
                                mk(0, 0, 0, 1, 2'd0, 3'd0, 2'd0, 2'd0,
                                   (f3 == 3'd5) ? {i30, f3} : {1'b0, f3})};
            7'b0110111: return {1'b0, mk(0, 0, 0, 1, 2'b10, 3'b011, 2'd0, 2'd0, 4'b1111)};
            7'b0010111: return {1'b0, mk(0, 0, 0, 1, 2'b01, 3'b011, 2'd0, 2'd0, 4'b0000)};
            7'b1101111: return {1'b0, mk(0, 0, 0, 0, 2'd0, 3'b100, 2'b10, 2'b10, 4'b0000)};
            7'b1100111: return {1'b0, mk(0, 0, 0, 0, 2'd0, 3'b000, 2'b11, 2'b10, 4'b0000)};
            7'b1100011: return {(f3 == 3'd2) || (f3 == 3'd3),
                                mk(1, 0, 0, 0, 2'd0, 3'b010, 2'b01, 2'd0, 4'b1000)};
            7'b0000011: return {1'b0, mk(0, 1, 0, 1, 2'd0, 3'b000, 2'd0, 2'b01, 4'b0000)};
            7'b0100011: return {1'b0, mk(0, 0, 1, 1, 2'd0, 3'b001, 2'd0, 2'd0, 4'b0000)};
            default:    return {1'b1, 17'd0};
        endcase
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input cyc_t c, input logic [16:0] ctl_exp);
        check_val("strobes", 32'({mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write}),
                  32'({c.req, c.we, c.asel, c.irw, c.pcw, c.rgw}));
        if (!c.trapd)
            check_val("controls", 32'(dut_ctl), 32'(ctl_exp));
        check_val("instret", 32'(instret), 32'(exp_instret));
        check_val("trap_fault", 32'({trap, fault}), 32'({c.trapd, c.flt}));
    endtask

    task automatic do_reset();
        halt    = 1'b0;
        mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_strobes", 32'({mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write}), 32'd0);
        check_val("reset_controls", 32'(dut_ctl), 32'd0);
        check_val("reset_instret", 32'(instret), 32'd0);
        check_val("reset_trap_fault", 32'({trap, fault}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        exp_instret = '0;
        prev_ctl    = '0;
    endtask

    // halt_mode: 0 halt low, 1 random, 2 high wherever it is not forced.
    task automatic applyStimulus(input logic [31:0] word, input int stall, input int fw,
                                 input int mw, input logic [16:0] ctl, input logic ill,
                                 input int halt_mode);
        cyc_t       q[$];
        cyc_t       c;
        logic       trapped;
        logic [1:0] trap_flt;
        int         nf, nm;
        trapped  = 1'b0;
        trap_flt = 2'b00;
        for (int i = 0; i < stall; i++) begin
            c = '0; c.halt_forced = 1'b1; c.halt_val = 1'b1; q.push_back(c);
        end
        nf = (fw >= TMO) ? TMO : fw;
        for (int i = 0; i < nf; i++) begin
            c = '0; c.fetch = 1'b1; c.req = 1'b1; c.halt_forced = (i == 0); q.push_back(c);
        end
        if (fw >= TMO) begin
            trapped = 1'b1; trap_flt = 2'b10;
        end else begin
            c = '0; c.fetch = 1'b1; c.req = 1'b1; c.ack = 1'b1; c.irw = 1'b1;
            c.halt_forced = (nf == 0); q.push_back(c);
            c = '0; q.push_back(c);
            if (ill) begin
                trapped = 1'b1; trap_flt = 2'b01;
            end else begin
                c = '0; c.new_ctl = 1'b1; c.pcw = ctl[16]; q.push_back(c);
                if (ctl[15] || ctl[14]) begin
                    nm = (mw >= TMO) ? TMO : mw;
                    for (int i = 0; i < nm; i++) begin
                        c = '0; c.new_ctl = 1'b1; c.req = 1'b1; c.asel = 1'b1; c.we = ctl[14];
                        q.push_back(c);
                    end
                    if (mw >= TMO) begin
                        trapped = 1'b1; trap_flt = 2'b10;
                    end else begin
                        c = '0; c.new_ctl = 1'b1; c.req = 1'b1; c.asel = 1'b1; c.we = ctl[14];
                        c.ack = 1'b1; c.pcw = ctl[14]; q.push_back(c);
                    end
                end
                if (!trapped && !ctl[16] && !ctl[14]) begin
                    c = '0; c.new_ctl = 1'b1; c.rgw = 1'b1; c.pcw = 1'b1; q.push_back(c);
                end
            end
        end
        if (trapped) begin
            for (int i = 0; i < 3; i++) begin
                c = '0; c.trapd = 1'b1; c.flt = trap_flt; q.push_back(c);
            end
        end
        foreach (q[k]) begin
            @(negedge clk);
            if (q[k].halt_forced)  halt = q[k].halt_val;
            else if (halt_mode == 2) halt = 1'b1;
            else if (halt_mode == 1) halt = ($urandom_range(0, 1) != 0);
            else                     halt = 1'b0;
            mem_ack = q[k].req ? q[k].ack : ($urandom_range(0, 1) != 0);
            instr   = q[k].fetch ? word : $urandom;
            #1;
            checkOutput(q[k], q[k].new_ctl ? ctl : prev_ctl);
            if (q[k].pcw) exp_instret = exp_instret + 1'b1;
        end
        if (trapped) do_reset();
        else         prev_ctl = ctl;
    endtask

    task automatic run_ref(input logic [31:0] w, input int stall, input int fw,
                           input int mw, input int halt_mode);
        logic [17:0] r;
        r = decode_ref(w);
        applyStimulus(w, stall, fw, mw, r[16:0], r[17], halt_mode);
    endtask

    function automatic logic [31:0] rand_word();
        logic [6:0]  ops[10];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0000000};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 9)];
        if (w[6:0] == 7'b0000000) w[6:0] = 7'($urandom);
        return w;
    endfunction

    function automatic int rand_wait();
        return ($urandom_range(0, 19) == 0) ? TMO + $urandom_range(0, 1) : $urandom_range(0, TMO - 1);
    endfunction

    vec_t tbl[18];

    initial begin
        halt    = 1'b0;
        mem_ack = 1'b0;
        instr   = '0;
        tbl[0]  = '{32'h002081B3, mk(0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 4'b0000), 1'b0};
        tbl[1]  = '{32'h4020D1B3, mk(0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 4'b1101), 1'b0};
        tbl[2]  = '{32'h00017197, mk(0, 0, 0, 1, 2'b01, 3'b011, 2'd0, 2'd0, 4'b0000), 1'b0};
        tbl[3]  = '{32'h123450B7, mk(0, 0, 0, 1, 2'b10, 3'b011, 2'd0, 2'd0, 4'b1111), 1'b0};
        tbl[4]  = '{32'h00508093, mk(0, 0, 0, 1, 2'd0, 3'd0, 2'd0, 2'd0, 4'b0000), 1'b0};
        tbl[5]  = '{32'h4050D093, mk(0, 0, 0, 1, 2'd0, 3'd0, 2'd0, 2'd0, 4'b1101), 1'b0};
        tbl[6]  = '{32'h4000C093, mk(0, 0, 0, 1, 2'd0, 3'd0, 2'd0, 2'd0, 4'b0100), 1'b0};
        tbl[7]  = '{32'h40009093, 17'd0, 1'b1};
        tbl[8]  = '{32'h40001033, 17'd0, 1'b1};
        tbl[9]  = '{32'h40000033, mk(0, 0, 0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 4'b1000), 1'b0};
        tbl[10] = '{32'h008000EF, mk(0, 0, 0, 0, 2'd0, 3'b100, 2'b10, 2'b10, 4'b0000), 1'b0};
        tbl[11] = '{32'h000080E7, mk(0, 0, 0, 0, 2'd0, 3'b000, 2'b11, 2'b10, 4'b0000), 1'b0};
        tbl[12] = '{32'h00208463, mk(1, 0, 0, 0, 2'd0, 3'b010, 2'b01, 2'd0, 4'b1000), 1'b0};
        tbl[13] = '{32'h0020A463, 17'd0, 1'b1};
        tbl[14] = '{32'h0020E463, mk(1, 0, 0, 0, 2'd0, 3'b010, 2'b01, 2'd0, 4'b1000), 1'b0};
        tbl[15] = '{32'h0000A183, mk(0, 1, 0, 1, 2'd0, 3'd0, 2'd0, 2'b01, 4'b0000), 1'b0};
        tbl[16] = '{32'h0020A223, mk(0, 0, 1, 1, 2'd0, 3'b001, 2'd0, 2'd0, 4'b0000), 1'b0};
        tbl[17] = '{32'h0000007F, 17'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 18; i++)
            applyStimulus(tbl[i].word, 0, 0, 0, tbl[i].ctl, tbl[i].ill, 0);

        // Load waiting three cycles in MEM: the ack lands on the last cycle before timeout.
        applyStimulus(tbl[15].word, 0, 0, 3, tbl[15].ctl, 1'b0, 0);
        applyStimulus(tbl[0].word, 0, TMO - 1, 0, tbl[0].ctl, 1'b0, 1);
        applyStimulus(tbl[0].word, 0, TMO, 0, tbl[0].ctl, 1'b0, 0);
        applyStimulus(tbl[15].word, 0, 0, TMO, tbl[15].ctl, 1'b0, 0);
        applyStimulus(tbl[16].word, 1, 1, TMO + 1, tbl[16].ctl, 1'b0, 0);
        // Store with halt high throughout MEM, then the following fetch stalls.
        applyStimulus(tbl[16].word, 0, 0, 2, tbl[16].ctl, 1'b0, 2);
        applyStimulus(tbl[0].word, 3, 0, 0, tbl[0].ctl, 1'b0, 0);
        applyStimulus(tbl[12].word, 2, 2, 0, tbl[12].ctl, 1'b0, 2);

        for (int n = 0; n < 150; n++)
            run_ref(rand_word(), $urandom_range(0, 2), rand_wait(), rand_wait(), 1);

        // Reset asserted while a fetch request is outstanding.
        applyStimulus(tbl[0].word, 0, 0, 0, tbl[0].ctl, 1'b0, 0);
        applyStimulus(tbl[12].word, 0, 0, 0, tbl[12].ctl, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            halt    = 1'b0;
            mem_ack = 1'b0;
            instr   = $urandom;
            #1;
            check_val("midwait_req", 32'(mem_req), 32'd1);
        end
        do_reset();
        applyStimulus(tbl[9].word, 0, 1, 0, tbl[9].ctl, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
